tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Owns the serial TX pin channel and shares it between two requesters: the instruction prefetcher (16-bit reads only) and the scheduler (reads and writes).
- Frames each granted command as start, command, then payload cycles, and generates the per-requester started/data_next strobes.
- Honours the scheduler's reserve_tx and tracks outstanding read replies so that RX capacity is never exceeded.

Parameters:
NSHIFT, 2, pin width, in bits per cycle
PAYLOAD_CYCLES, 8, payload cycles per frame
CMD_BITS, 2, command field width; must equal NSHIFT (one command cycle)
MAX_OUTSTANDING, 2, maximum number of reads awaiting replies
CMD_READ_16, 2'd0, read command code (the only code that counts as a read)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
sched_valid  in  1  scheduler command request
sched_cmd  in  CMD_BITS  scheduler command
sched_reply_wanted  in  1  a scheduler read expects an RX reply
sched_reserve  in  1  scheduler reserves the channel (blocks prefetch grants)
sched_data  in  NSHIFT  scheduler payload
sched_started  out  1  one-cycle pulse when a scheduler frame is granted
sched_data_next  out  1  scheduler payload consumed this cycle
pf_valid  in  1  prefetch read request
pf_data  in  NSHIFT  prefetch payload (address)
pf_started  out  1  one-cycle pulse when a prefetch frame is granted
pf_data_next  out  1  prefetch payload consumed this cycle
rx_done  in  1  one reply fully received
tx_active  out  1  a frame is in progress
tx_counter  out  $clog2(PAYLOAD_CYCLES)+1  frame cycle index
tx_done  out  1  last payload cycle
tx_pins  out  NSHIFT  serial output
outstanding  out  $clog2(MAX_OUTSTANDING+1)  replies pending

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, owner=none, outstanding=0. All outputs are 0 while in reset and the cycle after.
- States:
  - IDLE: nothing transmitted.
  - START (tx_counter=0): tx_pins all ones.
  - CMD (tx_counter=1): tx_pins = latched command.
  - PAYLOAD (tx_counter=2..PAYLOAD_CYCLES+1): tx_pins = owner data.
- IDLE drives tx_pins=0, tx_counter=0, tx_active=0. tx_active=1 in START, CMD and PAYLOAD.
- Grant is evaluated combinationally in IDLE and in the last PAYLOAD cycle, so back-to-back frames have zero idle gap.
  - Scheduler request is eligible when sched_valid and (sched_cmd!=CMD_READ_16, or outstanding<MAX_OUTSTANDING, or !sched_reply_wanted).
  - Prefetch request is eligible when pf_valid, !sched_reserve, !sched_valid, and outstanding<MAX_OUTSTANDING.
  - Fixed priority: scheduler over prefetch.
- Grant cycle:
  - Pulse sched_started or pf_started.
  - Latch owner and command (prefetch command = CMD_READ_16).
  - Next state = START.
  - Requesters may drop valid after the started pulse; the latched values are used.
- Outstanding count:
  - Increments on the grant of any read that expects a reply (all prefetch reads; scheduler reads with sched_reply_wanted=1).
  - Decrements on rx_done.
  - Both in the same cycle: unchanged.
  - rx_done at 0: ignored.
  - Eligibility always uses the registered count, so a same-cycle rx_done does not unblock a grant.
- PAYLOAD cycles:
  - The owner's data_next=1 and tx_pins = owner data combinationally. The requester advances its data after that edge.
  - The non-owner's data_next=0.
- tx_done=1 in the last PAYLOAD cycle (tx_counter=PAYLOAD_CYCLES+1).
  - Without a new grant, the next state is IDLE and owner is cleared.
- sched_reserve never aborts a frame in progress; it only suppresses prefetch grants.
- Reset mid-frame: the frame is abandoned immediately and outstanding is cleared.
- Frame length is exactly PAYLOAD_CYCLES+2 cycles (10 at defaults).

Test Plan:
1. Reset, then pf_valid=1 in IDLE:
   - pf_started pulses at cycle 0.
   - tx_pins=11, then 00, then 8 payload cycles with pf_data_next=1.
   - tx_done at tx_counter=9; outstanding=1.
2. sched_valid=1 with cmd=2'd2 (write) and pf_valid=1 in the same IDLE cycle:
   - The scheduler wins; CMD cycle pins=10; outstanding stays 0.
   - The prefetch frame starts immediately after tx_done, with no gap.
3. sched_reserve=1, pf_valid=1, sched_valid=0 for 20 cycles:
   - No grant and tx_active=0.
   - Dropping sched_reserve makes pf_started pulse the same cycle.
4. Two prefetch reads granted without rx_done:
   - outstanding=2 and a third pf_valid is not granted.
   - A sched write is still granted.
   - rx_done leads to a prefetch grant on the following cycle.
5. rx_done coincident with a read grant at outstanding=1: outstanding remains 1. rx_done at outstanding=0: remains 0.
6. Assert rst_n=0 at tx_counter=5 of a frame:
   - The next cycle shows tx_active=0, tx_pins=0, outstanding=0.
   - A new pf_valid after release restarts at START.

Source files
------------

// File: rtl/tx_arbiter.sv
// Shares the serial TX pins between the prefetcher and the scheduler. Each grant
// becomes a START, CMD, PAYLOAD frame, and reads awaiting RX replies are counted.
module tx_arbiter #(
  parameter int                  NSHIFT          = 2,
  parameter int                  PAYLOAD_CYCLES  = 8,
  parameter int                  CMD_BITS        = 2,
  parameter int                  MAX_OUTSTANDING = 2,
  parameter logic [CMD_BITS-1:0] CMD_READ_16     = 2'd0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sched_valid,
  input  logic [CMD_BITS-1:0]                  sched_cmd,
  input  logic                                 sched_reply_wanted,
  input  logic                                 sched_reserve,
  input  logic [NSHIFT-1:0]                    sched_data,
  output logic                                 sched_started,
  output logic                                 sched_data_next,
  input  logic                                 pf_valid,
  input  logic [NSHIFT-1:0]                    pf_data,
  output logic                                 pf_started,
  output logic                                 pf_data_next,
  input  logic                                 rx_done,
  output logic                                 tx_active,
  output logic [$clog2(PAYLOAD_CYCLES):0]      tx_counter,
  output logic                                 tx_done,
  output logic [NSHIFT-1:0]                    tx_pins,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_CYCLES + 1);
  localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CMD, S_PAYLOAD} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_SCHED, OWN_PF} owner_t;

  state_t              r_state;
  owner_t              r_owner;
  logic [CMD_BITS-1:0] r_cmd;
  logic [CW-1:0]       r_cnt;
  logic [OW-1:0]       r_outstanding;
  logic                r_ready;

  logic w_last, w_room, w_window, w_sched_elig, w_pf_elig;
  logic w_grant_sched, w_grant_pf, w_inc, w_dec;

  // Grant window is IDLE or the last payload cycle; r_ready keeps the cycle after reset quiet.
  always_comb begin
    w_last        = (r_state == S_PAYLOAD) && (r_cnt == LAST_CNT);
    w_room        = (r_outstanding < MAX_OUT);
    w_window      = rst_n && r_ready && ((r_state == S_IDLE) || w_last);
    w_sched_elig  = sched_valid &&
                    ((sched_cmd != CMD_READ_16) || w_room || !sched_reply_wanted);
    w_pf_elig     = pf_valid && !sched_reserve && !sched_valid && w_room;
    w_grant_sched = w_window && w_sched_elig;
    w_grant_pf    = w_window && w_pf_elig;
    w_inc         = w_grant_pf ||
                    (w_grant_sched && (sched_cmd == CMD_READ_16) && sched_reply_wanted);
    w_dec         = rx_done && (r_outstanding != {OW{1'b0}});
  end

  // Pin driver: all ones for START, latched command, then the owner's live payload.
  always_comb begin
    tx_pins = {NSHIFT{1'b0}};
    case (r_state)
      S_START: tx_pins = {NSHIFT{1'b1}};
      S_CMD:   tx_pins = r_cmd;
      S_PAYLOAD: begin
        if (r_owner == OWN_SCHED) begin
          tx_pins = sched_data;
        end else if (r_owner == OWN_PF) begin
          tx_pins = pf_data;
        end else begin
          tx_pins = {NSHIFT{1'b0}};
        end
      end
      default: tx_pins = {NSHIFT{1'b0}};
    endcase
  end

  assign sched_started   = w_grant_sched;
  assign pf_started      = w_grant_pf;
  assign sched_data_next = (r_state == S_PAYLOAD) && (r_owner == OWN_SCHED);
  assign pf_data_next    = (r_state == S_PAYLOAD) && (r_owner == OWN_PF);
  assign tx_active       = (r_state != S_IDLE);
  assign tx_counter      = r_cnt;
  assign tx_done         = w_last;
  assign outstanding     = r_outstanding;

  // Frame sequencer, owner/command latch and outstanding-reply counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_NONE;
      r_cmd         <= {CMD_BITS{1'b0}};
      r_cnt         <= {CW{1'b0}};
      r_outstanding <= {OW{1'b0}};
      r_ready       <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_inc && !w_dec) begin
        r_outstanding <= r_outstanding + OW'(1);
      end else if (w_dec && !w_inc) begin
        r_outstanding <= r_outstanding - OW'(1);
      end else begin
        r_outstanding <= r_outstanding;
      end

      if (w_grant_sched || w_grant_pf) begin
        r_state <= S_START;
        r_cnt   <= {CW{1'b0}};
        r_owner <= w_grant_sched ? OWN_SCHED : OWN_PF;
        r_cmd   <= w_grant_sched ? sched_cmd : CMD_READ_16;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_owner <= OWN_NONE;
          end
          S_START: begin
            r_state <= S_CMD;
            r_cnt   <= CW'(1);
          end
          S_CMD: begin
            r_state <= S_PAYLOAD;
            r_cnt   <= CW'(2);
          end
          S_PAYLOAD: begin
            if (w_last) begin
              r_state <= S_IDLE;
              r_cnt   <= {CW{1'b0}};
              r_owner <= OWN_NONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_owner <= OWN_NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed frame sequences, a grant-decision
// table, and randomized traffic against a frame-level reference model.
module tb_tx_arbiter;
  localparam int PC   = 8;
  localparam int MAXO = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sched_valid, sched_reply_wanted, sched_reserve;
  logic [1:0] sched_cmd, sched_data, pf_data;
  logic       sched_started, sched_data_next;
  logic       pf_valid, pf_started, pf_data_next;
  logic       rx_done, tx_active, tx_done;
  logic [3:0] tx_counter;
  logic [1:0] tx_pins, outstanding;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         pre;
    logic       sv;
    logic [1:0] cmd;
    logic       rw;
    logic       rsv;
    logic       pv;
    int         ss;
    int         ps;
    int         out;
  } vec_t;

  always #5 clk = ~clk;

  tx_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .sched_valid(sched_valid), .sched_cmd(sched_cmd),
    .sched_reply_wanted(sched_reply_wanted), .sched_reserve(sched_reserve),
    .sched_data(sched_data), .sched_started(sched_started),
    .sched_data_next(sched_data_next),
    .pf_valid(pf_valid), .pf_data(pf_data), .pf_started(pf_started),
    .pf_data_next(pf_data_next), .rx_done(rx_done),
    .tx_active(tx_active), .tx_counter(tx_counter), .tx_done(tx_done),
    .tx_pins(tx_pins), .outstanding(outstanding)
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    sched_valid = 1'b0; sched_cmd = 2'd0; sched_reply_wanted = 1'b0;
    sched_reserve = 1'b0; sched_data = 2'd0; pf_valid = 1'b0;
    pf_data = 2'd0; rx_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Runs until the pins go idle (bounded), then moves into the next cycle.
  task automatic finish_frame(input string name);
    int k;
    k = 0;
    settle();
    while (tx_active && k < 40) begin
      step();
      settle();
      k++;
    end
    check(name, tx_active, 0);
    step();
  endtask

  task automatic test1();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1; pf_valid = 1'b1; pf_data = 2'd1;
    settle();
    check("post_rst_pf_started", pf_started, 0);
    check("post_rst_active", tx_active, 0);
    check("post_rst_pins", tx_pins, 0);
    check("post_rst_outstanding", outstanding, 0);
    step();
    settle();
    check("t1_pf_started", pf_started, 1);
    check("t1_idle_active", tx_active, 0);
    step();
    pf_valid = 1'b0;
    settle();
    check("t1_start_pins", tx_pins, 3);
    check("t1_start_cnt", tx_counter, 0);
    check("t1_start_active", tx_active, 1);
    check("t1_outstanding", outstanding, 1);
    check("t1_start_restart", pf_started, 0);
    step();
    settle();
    check("t1_cmd_pins", tx_pins, 0);
    check("t1_cmd_cnt", tx_counter, 1);
    for (int i = 0; i < PC; i++) begin
      step();
      pf_data = 2'(i + 1);
      settle();
      check("t1_pay_pins", tx_pins, (i + 1) % 4);
      check("t1_pay_pf_dn", pf_data_next, 1);
      check("t1_pay_sched_dn", sched_data_next, 0);
      check("t1_pay_cnt", tx_counter, i + 2);
      check("t1_pay_done", tx_done, (i == PC - 1) ? 1 : 0);
    end
    step();
    settle();
    check("t1_after_active", tx_active, 0);
    check("t1_after_pins", tx_pins, 0);
    check("t1_after_outstanding", outstanding, 1);
    step();
  endtask

  task automatic test2();
    do_reset();
    sched_valid = 1'b1; sched_cmd = 2'd2; pf_valid = 1'b1; pf_data = 2'd1;
    settle();
    check("t2_sched_started", sched_started, 1);
    check("t2_pf_lost", pf_started, 0);
    step();
    sched_valid = 1'b0;
    settle();
    check("t2_start_pins", tx_pins, 3);
    step();
    settle();
    check("t2_cmd_pins", tx_pins, 2);
    check("t2_outstanding", outstanding, 0);
    check("t2_no_pf_midframe", pf_started, 0);
    for (int i = 0; i < PC; i++) begin
      step();
      sched_data = 2'(i);
      settle();
      check("t2_pay_pins", tx_pins, i % 4);
      check("t2_pay_sched_dn", sched_data_next, 1);
      check("t2_pay_pf_dn", pf_data_next, 0);
    end
    check("t2_done", tx_done, 1);
    check("t2_b2b_pf_started", pf_started, 1);
    step();
    pf_valid = 1'b0;
    settle();
    check("t2_b2b_active", tx_active, 1);
    check("t2_b2b_cnt", tx_counter, 0);
    check("t2_b2b_pins", tx_pins, 3);
    check("t2_b2b_outstanding", outstanding, 1);
    step();
    finish_frame("t2_end");
  endtask

  task automatic test3();
    int grants, act;
    grants = 0;
    act = 0;
    do_reset();
    sched_reserve = 1'b1; pf_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle();
      grants += int'(pf_started) + int'(sched_started);
      act += int'(tx_active);
      step();
    end
    check("t3_reserve_grants", grants, 0);
    check("t3_reserve_active", act, 0);
    sched_reserve = 1'b0;
    settle();
    check("t3_release_grant", pf_started, 1);
    step();
    pf_valid = 1'b0;
    finish_frame("t3_end");
  endtask

  task automatic test4();
    do_reset();
    pf_valid = 1'b1;
    settle();
    check("t4_grant1", pf_started, 1);
    step();
    repeat (PC + 1) step();
    settle();
    check("t4_b2b_cnt", tx_counter, PC + 1);
    check("t4_grant2", pf_started, 1);
    step();
    repeat (PC + 1) step();
    settle();
    check("t4_full_out", outstanding, 2);
    check("t4_no_grant3", pf_started, 0);
    step();
    settle();
    check("t4_idle_active", tx_active, 0);
    check("t4_idle_started", pf_started, 0);
    step();
    sched_valid = 1'b1; sched_cmd = 2'd1;
    settle();
    check("t4_sched_write", sched_started, 1);
    step();
    sched_valid = 1'b0;
    finish_frame("t4_write_end");
    settle();
    check("t4_still_full", outstanding, 2);
    check("t4_still_blocked", pf_started, 0);
    step();
    rx_done = 1'b1;
    settle();
    check("t4_rx_same_cycle", pf_started, 0);
    step();
    rx_done = 1'b0;
    settle();
    check("t4_after_rx_out", outstanding, 1);
    check("t4_after_rx_grant", pf_started, 1);
    step();
    pf_valid = 1'b0;
    settle();
    check("t4_regrant_out", outstanding, 2);
    step();
    finish_frame("t4_end");
  endtask

  task automatic test5();
    do_reset();
    rx_done = 1'b1;
    settle();
    step();
    rx_done = 1'b0;
    settle();
    check("t5_rx_at_zero", outstanding, 0);
    step();
    pf_valid = 1'b1;
    settle();
    step();
    pf_valid = 1'b0;
    finish_frame("t5_f1");
    settle();
    check("t5_out_one", outstanding, 1);
    step();
    pf_valid = 1'b1; rx_done = 1'b1;
    settle();
    check("t5_coinc_grant", pf_started, 1);
    step();
    pf_valid = 1'b0; rx_done = 1'b0;
    settle();
    check("t5_coinc_out", outstanding, 1);
    step();
    finish_frame("t5_f2");
  endtask

  task automatic test6();
    do_reset();
    pf_valid = 1'b1;
    settle();
    check("t6_grant", pf_started, 1);
    step();
    pf_valid = 1'b0;
    repeat (5) step();
    settle();
    check("t6_cnt5", tx_counter, 5);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; pf_valid = 1'b1;
    settle();
    check("t6_rst_active", tx_active, 0);
    check("t6_rst_pins", tx_pins, 0);
    check("t6_rst_outstanding", outstanding, 0);
    check("t6_rst_cnt", tx_counter, 0);
    check("t6_rst_started", pf_started, 0);
    step();
    settle();
    check("t6_regrant", pf_started, 1);
    step();
    pf_valid = 1'b0;
    settle();
    check("t6_restart_cnt", tx_counter, 0);
    check("t6_restart_pins", tx_pins, 3);
    check("t6_restart_active", tx_active, 1);
    step();
    finish_frame("t6_end");
  endtask

  task automatic run_table();
    vec_t v[12];
    //        pre  sv    cmd   rw    rsv   pv    ss ps out
    v[0]  = '{0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1, 0, 1};
    v[1]  = '{0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1, 0, 0};
    v[2]  = '{0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 1, 1};
    v[3]  = '{0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 0, 0, 0};
    v[4]  = '{2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 0, 0, 2};
    v[5]  = '{2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1, 0, 2};
    v[6]  = '{2, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1, 0, 2};
    v[7]  = '{2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 0, 2};
    v[8]  = '{0, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1, 0, 0};
    v[9]  = '{1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1, 0, 2};
    v[10] = '{1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 1, 2};
    v[11] = '{2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 0, 0, 2};
    for (int i = 0; i < 12; i++) begin
      do_reset();
      for (int k = 0; k < v[i].pre; k++) begin
        pf_valid = 1'b1;
        step();
        pf_valid = 1'b0;
        finish_frame("tbl_preload");
      end
      sched_valid = v[i].sv; sched_cmd = v[i].cmd; sched_reply_wanted = v[i].rw;
      sched_reserve = v[i].rsv; pf_valid = v[i].pv;
      settle();
      check($sformatf("tbl%0d_sched_started", i), sched_started, v[i].ss);
      check($sformatf("tbl%0d_pf_started", i), pf_started, v[i].ps);
      step();
      idle_inputs();
      finish_frame("tbl_end");
      settle();
      check($sformatf("tbl%0d_outstanding", i), outstanding, v[i].out);
      step();
    end
  endtask

  // Reference: a frame is a position 0..PC+1 (or -1 when idle); pins follow the frame layout.
  task automatic run_random();
    int m_pos, m_owner, m_out;
    logic [1:0] m_cmd;
    int last, window, room, s_el, p_el, e_ss, e_ps, e_pins, rd, dec;
    do_reset();
    m_pos = -1; m_owner = 0; m_out = 0; m_cmd = 2'd0;
    for (int c = 0; c < 600; c++) begin
      sched_valid        = ($urandom_range(0, 3) == 0);
      sched_cmd          = 2'($urandom_range(0, 3));
      sched_reply_wanted = ($urandom_range(0, 1) == 1);
      sched_reserve      = ($urandom_range(0, 4) == 0);
      pf_valid           = ($urandom_range(0, 1) == 1);
      sched_data         = 2'($urandom_range(0, 3));
      pf_data            = 2'($urandom_range(0, 3));
      rx_done            = (m_out > 0) && ($urandom_range(0, 3) == 0);
      settle();
      last   = (m_pos == PC + 1) ? 1 : 0;
      window = (m_pos < 0 || last == 1) ? 1 : 0;
      room   = (m_out < MAXO) ? 1 : 0;
      s_el   = (sched_valid && (sched_cmd != 2'd0 || room == 1 || !sched_reply_wanted)) ? 1 : 0;
      p_el   = (pf_valid && !sched_reserve && !sched_valid && room == 1) ? 1 : 0;
      e_ss   = window & s_el;
      e_ps   = window & p_el & (1 - s_el);
      if (m_pos < 0) e_pins = 0;
      else if (m_pos == 0) e_pins = 3;
      else if (m_pos == 1) e_pins = int'(m_cmd);
      else e_pins = (m_owner == 1) ? int'(sched_data) : int'(pf_data);
      check("rand_sched_started", sched_started, e_ss);
      check("rand_pf_started", pf_started, e_ps);
      check("rand_sched_dn", sched_data_next, (m_pos >= 2 && m_owner == 1) ? 1 : 0);
      check("rand_pf_dn", pf_data_next, (m_pos >= 2 && m_owner == 2) ? 1 : 0);
      check("rand_active", tx_active, (m_pos >= 0) ? 1 : 0);
      check("rand_cnt", tx_counter, (m_pos >= 0) ? m_pos : 0);
      check("rand_done", tx_done, last);
      check("rand_pins", tx_pins, e_pins);
      check("rand_outstanding", outstanding, m_out);
      rd  = (e_ps == 1 || (e_ss == 1 && sched_cmd == 2'd0 && sched_reply_wanted)) ? 1 : 0;
      dec = (rx_done && m_out > 0) ? 1 : 0;
      m_out = m_out + rd - dec;
      if (e_ss == 1 || e_ps == 1) begin
        m_pos = 0;
        m_owner = (e_ss == 1) ? 1 : 2;
        m_cmd = (e_ss == 1) ? sched_cmd : 2'd0;
      end else if (last == 1) begin
        m_pos = -1;
        m_owner = 0;
      end else if (m_pos >= 0) begin
        m_pos++;
      end
      step();
    end
    idle_inputs();
    finish_frame("rand_end");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test1();
    test2();
    test3();
    test4();
    test5();
    test6();
    run_table();
    run_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
